// File: rtl/entrada_numerica_pkg.sv
// Shared definitions for the keypad entry stage: key codes, debounce FSM states
// and the BCD-to-binary helper.
package entrada_numerica_pkg;

  localparam logic [4:0] TECLA_NINGUNA = 5'd16;
  localparam logic [4:0] TECLA_FALLA   = 5'd17;
  localparam logic [3:0] TECLA_BORRAR  = 4'hA;
  localparam logic [3:0] TECLA_LIMPIAR = 4'hE;
  localparam logic [3:0] TECLA_ENTER   = 4'hF;

  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    VALIDANDO = 2'd1,
    SOLTAR    = 2'd2
  } estado_t;

  // Three-digit decimal to binary; 999 fits in 10 bits, so no saturation.
  function automatic logic [9:0] bcd_a_binario(input logic [3:0] c,
                                               input logic [3:0] d,
                                               input logic [3:0] u);
    return ({6'd0, c} * 10'd100) + ({6'd0, d} * 10'd10) + {6'd0, u};
  endfunction

endpackage

// File: rtl/entrada_numerica_antirrebote_tecla.sv
// Debouncer for the scanned key code: accepts a press after DEBOUNCE identical
// samples and blocks new keys until DEBOUNCE consecutive no-key samples are seen.
module antirrebote_tecla
  import entrada_numerica_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] tecla,
  output logic       tecla_ok,
  output logic [3:0] codigo
);

  localparam logic [4:0] DEB = 5'(DEBOUNCE);

  estado_t    state_r, state_s;
  logic [3:0] cand_r, cand_s;
  logic [3:0] cnt_r, cnt_s;
  logic       hay_tecla_s;
  logic [4:0] cnt_mas_s;
  logic       fin_s;

  // Codes 16..31 (no key, scan fault) all read as "nothing pressed".
  assign hay_tecla_s = (tecla[4] == 1'b0);
  assign cnt_mas_s   = {1'b0, cnt_r} + 5'd1;
  assign fin_s       = (cnt_mas_s == DEB);
  assign codigo      = cand_r;

  // State, candidate and stability counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= REPOSO;
      cand_r  <= 4'd0;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      cand_r  <= cand_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic; tecla_ok fires on the edge the press is accepted.
  always_comb begin
    state_s  = state_r;
    cand_s   = cand_r;
    cnt_s    = cnt_r;
    tecla_ok = 1'b0;
    case (state_r)
      REPOSO: begin
        if (hay_tecla_s) begin
          cand_s  = tecla[3:0];
          cnt_s   = 4'd1;
          state_s = VALIDANDO;
        end else begin
          cnt_s = 4'd0;
        end
      end
      VALIDANDO: begin
        if (!hay_tecla_s) begin
          cnt_s   = 4'd0;
          state_s = REPOSO;
        end else if (tecla[3:0] != cand_r) begin
          cand_s = tecla[3:0];
          cnt_s  = 4'd1;
        end else if (fin_s) begin
          tecla_ok = 1'b1;
          cnt_s    = 4'd0;
          state_s  = SOLTAR;
        end else begin
          cnt_s = cnt_mas_s[3:0];
        end
      end
      SOLTAR: begin
        if (hay_tecla_s) begin
          cnt_s = 4'd0;
        end else if (fin_s) begin
          cnt_s   = 4'd0;
          state_s = REPOSO;
        end else begin
          cnt_s = cnt_mas_s[3:0];
        end
      end
      default: begin
        cnt_s   = 4'd0;
        state_s = REPOSO;
      end
    endcase
  end

endmodule

// File: rtl/entrada_numerica.sv
// Keypad entry stage: debounced keys edit a 3-digit BCD buffer; enter publishes
// the value in binary with a one-cycle strobe.
module entrada_numerica
  import entrada_numerica_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] tecla,
  output logic [3:0] bcd2,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0,
  output logic [1:0] num_dig,
  output logic [9:0] valor,
  output logic       valor_valido,
  output logic       error
);

  logic       tecla_ok_s;
  logic [3:0] codigo_s;

  logic [3:0] bcd2_r, bcd1_r, bcd0_r, bcd2_s, bcd1_s, bcd0_s;
  logic [1:0] num_dig_r, num_dig_s;
  logic [9:0] valor_r, valor_s;
  logic       valido_r, valido_s;
  logic       error_r, error_s;

  antirrebote_tecla #(.DEBOUNCE(DEBOUNCE)) u_antirrebote (
    .clk      (clk),
    .rst      (rst),
    .tecla    (tecla),
    .tecla_ok (tecla_ok_s),
    .codigo   (codigo_s)
  );

  // Action decode for the accepted key; acts on the acceptance edge itself.
  always_comb begin
    bcd2_s    = bcd2_r;
    bcd1_s    = bcd1_r;
    bcd0_s    = bcd0_r;
    num_dig_s = num_dig_r;
    valor_s   = valor_r;
    valido_s  = 1'b0;
    error_s   = 1'b0;
    if (tecla_ok_s) begin
      case (codigo_s)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: begin
          if (num_dig_r != 2'd3) begin
            bcd2_s    = bcd1_r;
            bcd1_s    = bcd0_r;
            bcd0_s    = codigo_s;
            num_dig_s = num_dig_r + 2'd1;
          end else begin
            num_dig_s = num_dig_r;
          end
        end
        TECLA_BORRAR: begin
          if (num_dig_r != 2'd0) begin
            bcd0_s    = bcd1_r;
            bcd1_s    = bcd2_r;
            bcd2_s    = 4'd0;
            num_dig_s = num_dig_r - 2'd1;
          end else begin
            num_dig_s = num_dig_r;
          end
        end
        TECLA_LIMPIAR: begin
          bcd2_s    = 4'd0;
          bcd1_s    = 4'd0;
          bcd0_s    = 4'd0;
          num_dig_s = 2'd0;
        end
        TECLA_ENTER: begin
          if (num_dig_r != 2'd0) begin
            valor_s   = bcd_a_binario(bcd2_r, bcd1_r, bcd0_r);
            valido_s  = 1'b1;
            bcd2_s    = 4'd0;
            bcd1_s    = 4'd0;
            bcd0_s    = 4'd0;
            num_dig_s = 2'd0;
          end else begin
            error_s = 1'b1;
          end
        end
        default: begin
          num_dig_s = num_dig_r;
        end
      endcase
    end else begin
      num_dig_s = num_dig_r;
    end
  end

  // Entry buffer, committed value and strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd2_r    <= 4'd0;
      bcd1_r    <= 4'd0;
      bcd0_r    <= 4'd0;
      num_dig_r <= 2'd0;
      valor_r   <= 10'd0;
      valido_r  <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      bcd2_r    <= bcd2_s;
      bcd1_r    <= bcd1_s;
      bcd0_r    <= bcd0_s;
      num_dig_r <= num_dig_s;
      valor_r   <= valor_s;
      valido_r  <= valido_s;
      error_r   <= error_s;
    end
  end

  assign bcd2         = bcd2_r;
  assign bcd1         = bcd1_r;
  assign bcd0         = bcd0_r;
  assign num_dig      = num_dig_r;
  assign valor        = valor_r;
  assign valor_valido = valido_r;
  assign error        = error_r;

endmodule

// File: tb/tb_entrada_numerica.sv
// Self-checking bench for entrada_numerica: table-driven key presses with a
// strobe scoreboard, plus hand sequences for glitches, latency and reset.
module tb_entrada_numerica;
  import entrada_numerica_pkg::*;

  localparam int D = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] tecla;
  logic [3:0] bcd2, bcd1, bcd0;
  logic [1:0] num_dig;
  logic [9:0] valor;
  logic       valor_valido, error;

  always #5 clk = ~clk;

  entrada_numerica #(.DEBOUNCE(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .tecla        (tecla),
    .bcd2         (bcd2),
    .bcd1         (bcd1),
    .bcd0         (bcd0),
    .num_dig      (num_dig),
    .valor        (valor),
    .valor_valido (valor_valido),
    .error        (error)
  );

  typedef struct {
    logic       es_error;
    logic [9:0] valor;
  } evento_t;

  typedef struct {
    logic [4:0] k;
    int         hold;
    logic [3:0] e2, e1, e0;
    logic [1:0] en;
    int         ev_kind;  // 0 none, 1 valor_valido, 2 error
    int         ev_val;
  } vec_t;

  evento_t cola[$];
  vec_t    tabla[22];
  int      n_cmp = 0;
  int      n_fail = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic press(input logic [4:0] k, input int hold, input int rel);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      tecla = k;
    end
    for (int i = 0; i < rel; i++) begin
      @(negedge clk);
      tecla = 5'd16;
    end
  endtask

  task automatic chk_buf(input string nm, input int e2, input int e1, input int e0, input int en);
    chk({nm, ".bcd2"}, int'(bcd2), e2);
    chk({nm, ".bcd1"}, int'(bcd1), e1);
    chk({nm, ".bcd0"}, int'(bcd0), e0);
    chk({nm, ".num_dig"}, int'(num_dig), en);
  endtask

  // Scoreboard: every strobe must match the next expected event.
  evento_t ev;
  always @(negedge clk) begin
    if (!rst && (valor_valido || error)) begin
      if (cola.size() == 0) begin
        chk("strobe_unexpected", int'({valor_valido, error}), 0);
      end else begin
        ev = cola.pop_front();
        chk("strobe_kind", int'({valor_valido, error}), ev.es_error ? 1 : 2);
        chk("strobe_valor", int'(valor), int'(ev.valor));
      end
    end
  end

  initial begin
    logic [4:0] glitch [12];
    int w;

    tabla[0]  = '{5'd4,  5,  4'd0, 4'd0, 4'd4, 2'd1, 0, 0};
    tabla[1]  = '{5'd2,  5,  4'd0, 4'd4, 4'd2, 2'd2, 0, 0};
    tabla[2]  = '{5'd7,  5,  4'd4, 4'd2, 4'd7, 2'd3, 0, 0};
    tabla[3]  = '{5'd15, 5,  4'd0, 4'd0, 4'd0, 2'd0, 1, 427};
    tabla[4]  = '{5'd1,  5,  4'd0, 4'd0, 4'd1, 2'd1, 0, 0};
    tabla[5]  = '{5'd2,  5,  4'd0, 4'd1, 4'd2, 2'd2, 0, 0};
    tabla[6]  = '{5'd3,  5,  4'd1, 4'd2, 4'd3, 2'd3, 0, 0};
    tabla[7]  = '{5'd9,  5,  4'd1, 4'd2, 4'd3, 2'd3, 0, 0};
    tabla[8]  = '{5'd10, 5,  4'd0, 4'd1, 4'd2, 2'd2, 0, 0};
    tabla[9]  = '{5'd14, 5,  4'd0, 4'd0, 4'd0, 2'd0, 0, 0};
    tabla[10] = '{5'd15, 5,  4'd0, 4'd0, 4'd0, 2'd0, 2, 427};
    tabla[11] = '{5'd10, 5,  4'd0, 4'd0, 4'd0, 2'd0, 0, 0};
    tabla[12] = '{5'd12, 5,  4'd0, 4'd0, 4'd0, 2'd0, 0, 0};
    tabla[13] = '{5'd9,  5,  4'd0, 4'd0, 4'd9, 2'd1, 0, 0};
    tabla[14] = '{5'd8,  40, 4'd0, 4'd9, 4'd8, 2'd2, 0, 0};
    tabla[15] = '{5'd10, 5,  4'd0, 4'd0, 4'd9, 2'd1, 0, 0};
    tabla[16] = '{5'd15, 5,  4'd0, 4'd0, 4'd0, 2'd0, 1, 9};
    tabla[17] = '{5'd17, 10, 4'd0, 4'd0, 4'd0, 2'd0, 0, 0};
    tabla[18] = '{5'd0,  5,  4'd0, 4'd0, 4'd0, 2'd1, 0, 0};
    tabla[19] = '{5'd0,  5,  4'd0, 4'd0, 4'd0, 2'd2, 0, 0};
    tabla[20] = '{5'd5,  5,  4'd0, 4'd0, 4'd5, 2'd3, 0, 0};
    tabla[21] = '{5'd15, 5,  4'd0, 4'd0, 4'd0, 2'd0, 1, 5};

    glitch = '{5'd5, 5'd16, 5'd5, 5'd16, 5'd6, 5'd17, 5'd6, 5'd17,
               5'd7, 5'd6, 5'd7, 5'd6};

    rst   = 1'b1;
    tecla = 5'd16;
    repeat (3) @(negedge clk);
    chk_buf("reset", 0, 0, 0, 0);
    chk("reset.valor", int'(valor), 0);
    chk("reset.valor_valido", int'(valor_valido), 0);
    chk("reset.error", int'(error), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 22; i++) begin
      if (tabla[i].ev_kind == 1) cola.push_back('{1'b0, 10'(tabla[i].ev_val)});
      if (tabla[i].ev_kind == 2) cola.push_back('{1'b1, 10'(tabla[i].ev_val)});
      press(tabla[i].k, tabla[i].hold, 5);
      chk_buf($sformatf("vec%0d", i), int'(tabla[i].e2), int'(tabla[i].e1),
              int'(tabla[i].e0), int'(tabla[i].en));
    end
    chk("valor_after_table", int'(valor), 5);

    // One-cycle glitches and alternating candidates never reach DEBOUNCE.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      tecla = glitch[i];
    end
    press(5'd16, 0, 8);
    chk_buf("glitch", 0, 0, 0, 0);

    // Acceptance latency: first seen at edge k, taken at edge k+D-1.
    @(negedge clk);
    tecla = 5'd1;
    for (int i = 0; i < D - 1; i++) begin
      @(negedge clk);
      chk($sformatf("lat_before%0d", i), int'(num_dig), 0);
    end
    @(negedge clk);
    chk("lat_at.num_dig", int'(num_dig), 1);
    chk("lat_at.bcd0", int'(bcd0), 1);
    press(5'd16, 0, 6);

    // Reset while key 6 is being validated, key held through deassertion.
    @(negedge clk);
    tecla = 5'd6;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_buf("midrst", 0, 0, 0, 0);
    chk("midrst.valor", int'(valor), 0);
    chk("midrst.strobes", int'({valor_valido, error}), 0);
    rst = 1'b0;
    for (int i = 0; i < D - 1; i++) begin
      @(negedge clk);
      chk($sformatf("postrst_before%0d", i), int'(num_dig), 0);
    end
    @(negedge clk);
    chk_buf("postrst_at", 0, 0, 6, 1);
    press(5'd16, 0, 6);
    cola.push_back('{1'b0, 10'd6});
    press(5'd15, 5, 5);
    chk_buf("final", 0, 0, 0, 0);
    chk("final.valor", int'(valor), 6);

    w = 0;
    while (cola.size() > 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("pending_events", cola.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/entrada_numerica.md
# entrada_numerica

Keypad entry stage that sits directly downstream of the keypad scanning driver. Samples the driver's 5-bit key code every clock, debounces presses, and edits a 3-digit decimal entry buffer (digits, backspace, clear, enter). On enter, publishes the entered number as binary with a one-cycle strobe for the control logic, and continuously exposes the BCD digits for the 7-segment display.

## Interface

- `DEBOUNCE`, default 3: consecutive identical samples required to accept a press or a release (legal range 2..15).
- `clk`  input  1  system clock (100 Hz keypad domain).
- `rst`  input  1  asynchronous, active-high reset.
- `tecla`  input  5  key code from the driver:
  - 0..9 = digits
  - 0xA = backspace
  - 0xB..0xD = ignored
  - 0xE = clear
  - 0xF = enter
  - 16 = no key
  - 17 = scan fault, treated as no key
- `bcd2`, `bcd1`, `bcd0`  output  4 each  entry buffer, hundreds/tens/units.
- `num_dig`  output  2  digits currently entered (0..3).
- `valor`  output  10  last committed value, binary 0..999.
- `valor_valido`  output  1  one-cycle strobe when `valor` updates.
- `error`  output  1  one-cycle strobe on an enter with an empty buffer.

## Operation

- Reset values: all BCD digits 0, `num_dig` 0, `valor` 0, both strobes 0, FSM in REPOSO, stability counter 0.
- FSM states:
  - REPOSO: waiting for a key. A sample in 0..15 loads the candidate code, sets the counter to 1 and enters VALIDANDO.
  - VALIDANDO: the candidate is sampled again.
    - Same code: counter increments.
    - Different code in 0..15: becomes the new candidate, counter back to 1.
    - Code 16 or 17: back to REPOSO.
    - On the edge where the counter would reach `DEBOUNCE`, the press is accepted, its action is executed, the counter clears, and the FSM enters SOLTAR.
  - SOLTAR: counts consecutive 16/17 samples and returns to REPOSO after `DEBOUNCE` of them. Any code in 0..15 resets the count. New keys are never accepted in SOLTAR, so there is no auto-repeat.
- Actions, each executed exactly once per accepted press:
  - Digit d, `num_dig`<3: shift left (`bcd2`←`bcd1`, `bcd1`←`bcd0`, `bcd0`←d), `num_dig`+1.
  - Digit d, `num_dig`=3: ignored (buffer full, contents unchanged).
  - 0xA, `num_dig`>0: shift right (`bcd0`←`bcd1`, `bcd1`←`bcd2`, `bcd2`←0), `num_dig`−1. With `num_dig`=0 it is a no-op.
  - 0xE: all digits 0, `num_dig` 0.
  - 0xF, `num_dig`>0: `valor`←`bcd2`·100+`bcd1`·10+`bcd0`, pulse `valor_valido`, then clear the buffer as for 0xE.
  - 0xF, `num_dig`=0: pulse `error`; `valor` is unchanged.
  - 0xB..0xD: no action, but the FSM still goes through SOLTAR.
- Arithmetic: the weighted sum is computed at ≥10 bits. The maximum 999 fits in 10 bits, so no saturation is needed.
- Reset asserted mid-press: immediate return to reset values. A key still held after reset deasserts is treated as a new press.

## Timing

- The input is used directly with no extra synchronizer, because the driver shares `clk`.
- Press latency: a stable key first present at edge k is accepted at edge k+DEBOUNCE−1. The buffer, `num_dig`, `valor` and the strobes update on that same edge.
- The strobes are high for exactly one cycle. `valor_valido` and `error` are never asserted together.
- Minimum spacing between two accepted presses is 2·DEBOUNCE cycles.
- The BCD outputs and `num_dig` are registered and stable between accepted presses.

## Structure

- Shared package holds:
  - key-code constants: `TECLA_NINGUNA`=16, `TECLA_FALLA`=17, `TECLA_BORRAR`=0xA, `TECLA_LIMPIAR`=0xE, `TECLA_ENTER`=0xF;
  - the FSM state encoding (REPOSO, VALIDANDO, SOLTAR).
- One natural sub-module: `antirrebote_tecla`. It contains the FSM and counter, and outputs a one-cycle `tecla_ok` pulse plus the accepted `codigo[3:0]`.
- The top level keeps the entry buffer, the action decode and the BCD-to-binary conversion.

## Test plan

- Press 4, 2, 7 (each held 5 cycles, 5 cycles released) then 0xF → `bcd2..0`=4,2,7 before enter; afterwards `valor`=427, `valor_valido` high one cycle, buffer cleared, `num_dig`=0.
- Key 5 glitching 5,16,5,16 (1 cycle each) with `DEBOUNCE`=3 → no acceptance, buffer unchanged.
- Key 8 held 40 cycles → exactly one digit entered, `num_dig`=1, no repeat.
- Enter 1,2,3,9 → `num_dig`=3, digits 1,2,3 (9 ignored). Then 0xA → `bcd2..0`=0,1,2, `num_dig`=2. Then 0xE → all 0.
- 0xF on an empty buffer → `error` pulses once, `valor` keeps its previous value (e.g. 427).
- Assert `rst` while key 6 is in VALIDANDO → all outputs at reset values. Key 6 held through deassertion → accepted DEBOUNCE−1 edges after the first post-reset sample; code 17 sequences never produce an action.
